// File: rtl/state_logger_pkg.sv
// Shared defaults and the history entry layout for the state history logger.
package state_logger_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_TS_WIDTH = 16;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]    state;
        logic [DEF_TS_WIDTH-1:0] dwell;
    } entry_t;

endpackage

// File: rtl/state_history_ring.sv
// Ring buffer of {state, dwell} history entries with one write port and one
// registered read port indexed backwards from the newest entry.
module state_history_ring
    import state_logger_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int TS_WIDTH = DEF_TS_WIDTH,
    localparam int IDXW    = $clog2(DEPTH)
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_state,
    input  logic [TS_WIDTH-1:0] wr_dwell,
    input  logic [IDXW-1:0]     rd_idx,
    input  logic [IDXW:0]       count,
    output logic [WIDTH-1:0]    rd_state,
    output logic [TS_WIDTH-1:0] rd_dwell
);

    typedef struct packed {
        logic [WIDTH-1:0]    state;
        logic [TS_WIDTH-1:0] dwell;
    } slot_t;

    slot_t           mem [DEPTH];
    logic [IDXW-1:0] wp;
    logic [IDXW-1:0] rd_addr;

    // Offset by 2*DEPTH so the subtraction never goes negative before the modulo.
    always_comb begin
        rd_addr = IDXW'((int'(wp) + 2 * DEPTH - 1 - int'(rd_idx)) % DEPTH);
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp       <= '0;
            rd_state <= '0;
            rd_dwell <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= '{state: wr_state, dwell: wr_dwell};
                wp      <= (wp == IDXW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            end
            if ({1'b0, rd_idx} < count) begin
                rd_state <= mem[rd_addr].state;
                rd_dwell <= mem[rd_addr].dwell;
            end else begin
                rd_state <= '0;
                rd_dwell <= '0;
            end
        end
    end

endmodule

// File: rtl/state_history_logger.sv
// Watches a state code, timestamps how long each state lasted and keeps the
// most recent DEPTH previous states in a readable history ring.
module state_history_logger
    import state_logger_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int TS_WIDTH = DEF_TS_WIDTH,
    localparam int IDXW    = $clog2(DEPTH)
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic                iClear,
    input  logic                iFreeze,
    input  logic [WIDTH-1:0]    iDbgSt,
    input  logic [IDXW-1:0]     iRdIdx,
    output logic [WIDTH-1:0]    oCurState,
    output logic [TS_WIDTH-1:0] oCurDwell,
    output logic [WIDTH-1:0]    oRdState,
    output logic [TS_WIDTH-1:0] oRdDwell,
    output logic [IDXW:0]       oCount,
    output logic                oOverflow
);

    localparam logic [IDXW:0] CNT_FULL = (IDXW + 1)'(DEPTH);

    logic change;

    assign change = (iDbgSt != oCurState) && !iFreeze && !iClear;

    always_ff @(posedge iClk) begin
        if (!iRst_n || iClear) begin
            oCurState <= iDbgSt;
            oCurDwell <= '0;
            oCount    <= '0;
            oOverflow <= 1'b0;
        end else if (!iFreeze) begin
            if (change) begin
                oCurState <= iDbgSt;
                oCurDwell <= '0;
                // A full ring means this push overwrites the oldest entry.
                if (oCount == CNT_FULL) begin
                    oOverflow <= 1'b1;
                end else begin
                    oCount <= oCount + 1'b1;
                end
            end else if (oCurDwell != '1) begin
                oCurDwell <= oCurDwell + 1'b1;
            end
        end
    end

    state_history_ring #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .TS_WIDTH (TS_WIDTH)
    ) u_ring (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .clear    (iClear),
        .wr_en    (change),
        .wr_state (oCurState),
        .wr_dwell (oCurDwell),
        .rd_idx   (iRdIdx),
        .count    (oCount),
        .rd_state (oRdState),
        .rd_dwell (oRdDwell)
    );

endmodule

// File: tb/tb_state_history_logger.sv
// Directed bench for state_history_logger with WIDTH=8, DEPTH=4, TS_WIDTH=4.
module tb_state_history_logger;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       iClear;
    logic       iFreeze;
    logic [7:0] iDbgSt;
    logic [1:0] iRdIdx;
    logic [7:0] oCurState;
    logic [3:0] oCurDwell;
    logic [7:0] oRdState;
    logic [3:0] oRdDwell;
    logic [2:0] oCount;
    logic       oOverflow;

    int checks   = 0;
    int failures = 0;

    state_history_logger #(
        .WIDTH    (8),
        .DEPTH    (4),
        .TS_WIDTH (4)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iClear    (iClear),
        .iFreeze   (iFreeze),
        .iDbgSt    (iDbgSt),
        .iRdIdx    (iRdIdx),
        .oCurState (oCurState),
        .oCurDwell (oCurDwell),
        .oRdState  (oRdState),
        .oRdDwell  (oRdDwell),
        .oCount    (oCount),
        .oOverflow (oOverflow)
    );

    always #5 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] st);
        iRst_n  = 1'b0;
        iClear  = 1'b0;
        iFreeze = 1'b0;
        iDbgSt  = st;
        iRdIdx  = 2'd0;
        step();
        iRst_n  = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(8'h11);
        checks++; if (oCurState !== 8'h11) begin failures++; $display("[TB] FAIL reset_cur got=%h exp=11", oCurState); end
        checks++; if (oCurDwell !== 4'h0) begin failures++; $display("[TB] FAIL reset_dwell got=%h exp=0", oCurDwell); end
        checks++; if (oCount !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", oCount); end
        checks++; if (oOverflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", oOverflow); end
        checks++; if (oRdState !== 8'h00 || oRdDwell !== 4'h0) begin failures++; $display("[TB] FAIL reset_rd got=%h/%h exp=00/0", oRdState, oRdDwell); end
    endtask

    task automatic test_basic_push();
        do_reset(8'h11);
        repeat (3) step();
        checks++; if (oCurDwell !== 4'h3) begin failures++; $display("[TB] FAIL basic_dwell3 got=%h exp=3", oCurDwell); end
        iDbgSt = 8'h22;
        iRdIdx = 2'd0;
        step();
        checks++; if (oCurState !== 8'h22) begin failures++; $display("[TB] FAIL basic_cur got=%h exp=22", oCurState); end
        checks++; if (oCount !== 3'd1) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=1", oCount); end
        checks++; if (oCurDwell !== 4'h0) begin failures++; $display("[TB] FAIL basic_dwell0 got=%h exp=0", oCurDwell); end
        step();
        checks++; if (oRdState !== 8'h11 || oRdDwell !== 4'h3) begin failures++; $display("[TB] FAIL basic_rd0 got=%h/%h exp=11/3", oRdState, oRdDwell); end
        iRdIdx = 2'd2;
        step();
        checks++; if (oRdState !== 8'h00 || oRdDwell !== 4'h0) begin failures++; $display("[TB] FAIL beyond_count_rd2 got=%h/%h exp=00/0", oRdState, oRdDwell); end
        iRdIdx = 2'd1;
        step();
        checks++; if (oRdState !== 8'h00 || oRdDwell !== 4'h0) begin failures++; $display("[TB] FAIL beyond_count_rd1 got=%h/%h exp=00/0", oRdState, oRdDwell); end
    endtask

    task automatic test_dwell_saturate();
        do_reset(8'h33);
        repeat (14) step();
        checks++; if (oCurDwell !== 4'hE) begin failures++; $display("[TB] FAIL sat_dwell14 got=%h exp=e", oCurDwell); end
        repeat (6) step();
        checks++; if (oCurDwell !== 4'hF) begin failures++; $display("[TB] FAIL sat_dwell20 got=%h exp=f", oCurDwell); end
        checks++; if (oCurState !== 8'h33 || oCount !== 3'd0) begin failures++; $display("[TB] FAIL sat_nochange got=%h/%0d exp=33/0", oCurState, oCount); end
    endtask

    task automatic test_overflow();
        logic [7:0] seq    [6] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5};
        logic [7:0] exp_st [4] = '{8'hE4, 8'hD3, 8'hC2, 8'hB1};
        do_reset(seq[0]);
        for (int i = 1; i < 6; i++) begin
            step();
            iDbgSt = seq[i];
            step();
            if (i == 4) begin
                checks++; if (oCount !== 3'd4 || oOverflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_full_noovf got=%0d/%b exp=4/0", oCount, oOverflow); end
            end
        end
        checks++; if (oCurState !== 8'hF5) begin failures++; $display("[TB] FAIL ovf_cur got=%h exp=f5", oCurState); end
        checks++; if (oCount !== 3'd4 || oOverflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%0d/%b exp=4/1", oCount, oOverflow); end
        for (int i = 0; i < 4; i++) begin
            iRdIdx = 2'(i);
            step();
            checks++; if (oRdState !== exp_st[i] || oRdDwell !== 4'h1) begin failures++; $display("[TB] FAIL ovf_rd%0d got=%h/%h exp=%h/1", i, oRdState, oRdDwell, exp_st[i]); end
        end
    endtask

    task automatic test_clear_priority();
        iClear  = 1'b1;
        iFreeze = 1'b1;
        iDbgSt  = 8'h55;
        iRdIdx  = 2'd0;
        step();
        checks++; if (oCurState !== 8'h55 || oCurDwell !== 4'h0) begin failures++; $display("[TB] FAIL clr_cur got=%h/%h exp=55/0", oCurState, oCurDwell); end
        checks++; if (oCount !== 3'd0 || oOverflow !== 1'b0) begin failures++; $display("[TB] FAIL clr_count got=%0d/%b exp=0/0", oCount, oOverflow); end
        iClear  = 1'b0;
        iFreeze = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iRdIdx = 2'(i);
            step();
            checks++; if (oRdState !== 8'h00 || oRdDwell !== 4'h0) begin failures++; $display("[TB] FAIL clr_rd%0d got=%h/%h exp=00/0", i, oRdState, oRdDwell); end
        end
    endtask

    task automatic test_freeze();
        do_reset(8'h10);
        iDbgSt = 8'h20;
        step();
        repeat (2) step();
        iFreeze = 1'b1;
        iDbgSt  = 8'h30;
        step();
        iDbgSt  = 8'h40;
        iRdIdx  = 2'd0;
        step();
        checks++; if (oCurState !== 8'h20 || oCurDwell !== 4'h2) begin failures++; $display("[TB] FAIL frz_hold got=%h/%h exp=20/2", oCurState, oCurDwell); end
        checks++; if (oCount !== 3'd1) begin failures++; $display("[TB] FAIL frz_count got=%0d exp=1", oCount); end
        checks++; if (oRdState !== 8'h10 || oRdDwell !== 4'h0) begin failures++; $display("[TB] FAIL frz_rd got=%h/%h exp=10/0", oRdState, oRdDwell); end
        iFreeze = 1'b0;
        step();
        checks++; if (oCurState !== 8'h40 || oCount !== 3'd2 || oCurDwell !== 4'h0) begin failures++; $display("[TB] FAIL frz_release got=%h/%0d/%h exp=40/2/0", oCurState, oCount, oCurDwell); end
        step();
        checks++; if (oRdState !== 8'h20 || oRdDwell !== 4'h2) begin failures++; $display("[TB] FAIL frz_push_rd got=%h/%h exp=20/2", oRdState, oRdDwell); end
        checks++; if (oCount !== 3'd2) begin failures++; $display("[TB] FAIL frz_single_push got=%0d exp=2", oCount); end
        iFreeze = 1'b1;
        iRst_n  = 1'b0;
        step();
        checks++; if (oCount !== 3'd0 || oCurDwell !== 4'h0 || oRdState !== 8'h00) begin failures++; $display("[TB] FAIL frz_reset got=%0d/%h/%h exp=0/0/00", oCount, oCurDwell, oRdState); end
        iRst_n  = 1'b1;
        iFreeze = 1'b0;
    endtask

    initial begin
        iRst_n  = 1'b0;
        iClear  = 1'b0;
        iFreeze = 1'b0;
        iDbgSt  = 8'h00;
        iRdIdx  = 2'd0;
        test_reset();
        test_basic_push();
        test_dwell_saturate();
        test_overflow();
        test_clear_priority();
        test_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/state_history_logger.md
STATE_HISTORY_LOGGER -- requirements
Module: state_history_logger

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the width of the logged state code.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of history entries (legal 2..16).
REQ-003 The block SHALL have parameter TS_WIDTH, default 16, meaning the width of the per-entry dwell counter.
REQ-004 The block SHALL have port iClk, input, 1 bit: the single clock; all logic is posedge iClk.
REQ-005 The block SHALL have port iRst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port iClear, input, 1 bit: synchronous history clear.
REQ-007 The block SHALL have port iFreeze, input, 1 bit: while high, the logger holds all contents.
REQ-008 The block SHALL have port iDbgSt, input, WIDTH bits: the monitored state code.
REQ-009 The block SHALL have port iRdIdx, input, IDXW = clog2(DEPTH) bits: the read index; 0 = most recent previous state.
REQ-010 The block SHALL have port oCurState, output, WIDTH bits: the current logged state.
REQ-011 The block SHALL have port oCurDwell, output, TS_WIDTH bits: cycles spent in oCurState, saturating.
REQ-012 The block SHALL have port oRdState, output, WIDTH bits: the state of entry iRdIdx, registered.
REQ-013 The block SHALL have port oRdDwell, output, TS_WIDTH bits: the dwell of entry iRdIdx, registered.
REQ-014 The block SHALL have port oCount, output, IDXW+1 bits: the number of valid entries (0..DEPTH).
REQ-015 The block SHALL have port oOverflow, output, 1 bit: sticky flag, set when an entry was overwritten.

Function
REQ-016 Storage SHALL be a DEPTH-entry ring of {state, dwell} with write pointer wp; the newest entry sits at wp-1 modulo DEPTH.
REQ-017 A change is detected when iDbgSt != oCurState, iFreeze=0 and iClear=0; on that edge the block SHALL apply REQ-018..REQ-020.
REQ-018 On a change: push {oCurState, oCurDwell} at wp, wp+1 mod DEPTH, oCurState<=iDbgSt, oCurDwell<=0.
REQ-019 On a change: oCount increments, saturating at DEPTH.
REQ-020 On a change with oCount==DEPTH: the oldest entry is overwritten and oOverflow<=1 (sticky until clear/reset).
REQ-021 With no change and iFreeze=0, oCurDwell SHALL increment by 1 per cycle, saturating at all-ones; it never wraps.
REQ-022 With iFreeze=1, the ring, wp, oCount, oOverflow, oCurState and oCurDwell SHALL hold; state changes during the freeze are not logged.
REQ-023 Read latency is 1 cycle: oRdState/oRdDwell at edge n+1 reflect iRdIdx and the ring contents before any push at edge n.
REQ-024 Entry selected = ring[(wp-1-iRdIdx) mod DEPTH]; if iRdIdx >= oCount, oRdState and oRdDwell SHALL be 0.
REQ-025 Reads SHALL be fully available while frozen; reads never alter state.
REQ-026 iClear=1 SHALL take priority over iFreeze and change detection.

Reset
REQ-027 On iRst_n=0 or iClear=1 at a clock edge: oCurState<=iDbgSt; oCurDwell<=0; all ring entries<=0; wp<=0; oCount<=0; oOverflow<=0; oRdState<=0; oRdDwell<=0.
REQ-028 Reset or clear arriving mid-operation (including while frozen) SHALL discard all history in that same edge; there is no asynchronous path.

Structure
REQ-029 Package state_logger_pkg SHALL hold the default WIDTH/DEPTH/TS_WIDTH constants and the entry struct typedef {state, dwell}.
REQ-030 The ring SHALL be sub-module state_history_ring: DEPTH×(WIDTH+TS_WIDTH) register array, one write port, one registered read port; change detection, dwell and count logic stay in the top.

Verification (WIDTH=8, DEPTH=4, TS_WIDTH=4)
REQ-031 Reset, then hold iDbgSt=0x11 for 3 cycles, then 0x22 -> oCurState=0x22, oCount=1, idx0 reads {0x11, dwell 3} one cycle after iRdIdx=0 is applied.
REQ-032 Hold one state for 20 cycles -> oCurDwell sticks at 0xF.
REQ-033 Drive 6 distinct states A..F -> oCount=4, oOverflow=1, idx0..3 = E, D, C, B; idx3 never reads A.
REQ-034 iFreeze=1, then change iDbgSt twice -> oCurState, oCount and oCurDwell are unchanged; after release, one push of the old current state occurs on the first mismatch.
REQ-035 iClear and iFreeze high together, with a change in the same cycle -> all cleared, oCurState=iDbgSt, oCount=0; any iRdIdx then returns 0.
REQ-036 iRdIdx=2 with oCount=1 -> oRdState=0 and oRdDwell=0.
